// File: rtl/conv_fetch_sequencer_if.sv
// Wishbone read-only bus between the fetch sequencer (master) and the memory port (slave).
interface conv_fetch_sequencer_if;
  logic [29:0] wb_adr;
  logic        wb_cyc;
  logic        wb_stb;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic [31:0] wb_dat_miso;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_adr, wb_cyc, wb_stb, wb_sel, wb_we,
    input  wb_dat_miso, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_cyc, wb_stb, wb_sel, wb_we,
    output wb_dat_miso, wb_ack, wb_err
  );
endinterface

// File: rtl/conv_fetch_sequencer.sv
// Walks one convolution filter window, fetching image/filter words over Wishbone and
// handing them to the MAC datapath as lane-masked pairs, with bounded read retry.
module conv_fetch_sequencer #(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           cfg_image_base,
  input  logic [15:0]           cfg_image_stride,
  input  logic [31:0]           cfg_filter_base,
  input  logic [15:0]           cfg_filter_w,
  input  logic [15:0]           cfg_filter_h,
  input  logic [15:0]           cfg_out_x,
  input  logic [15:0]           cfg_out_y,
  conv_fetch_sequencer_if.master bus,
  output logic                  pair_valid,
  input  logic                  pair_ready,
  output logic [31:0]           pair_img,
  output logic [31:0]           pair_flt,
  output logic [3:0]            pair_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned        RetryW   = $clog2(MAX_RETRY + 2);
  localparam logic [RetryW-1:0]  RetryMax = RetryW'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle, StCheck, StImgReq, StFltReq, StRetryGap, StPresent, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       img_base_q, flt_base_q;
  logic [15:0]       img_stride_q, flt_w_q, flt_h_q, out_x_q, out_y_q;
  logic [15:0]       fx_q, fx_d, fy_q, fy_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              gap_flt_q, gap_flt_d;
  logic [31:0]       img_q, img_d, flt_q, flt_d;
  logic              error_q, error_d;
  logic              load_cfg;

  logic [31:0]       flt_row, img_addr, flt_addr, fx_next;
  logic              last_col, last_row, misaligned;
  logic [3:0]        lane_mask;
  logic              unused_bits;

  // Address generation from registered walk state; wraps modulo 2^32.
  assign flt_row  = (32'(flt_w_q) + 32'd3) & ~32'd3;
  assign img_addr = img_base_q + (32'(out_y_q) + 32'(fy_q)) * 32'(img_stride_q)
                  + 32'(out_x_q) + 32'(fx_q);
  assign flt_addr = flt_base_q + 32'(fy_q) * flt_row + 32'(fx_q);

  assign fx_next    = 32'(fx_q) + 32'd4;
  assign last_col   = !(fx_next < 32'(flt_w_q));
  assign last_row   = (32'(fy_q) + 32'd1) == 32'(flt_h_q);
  assign misaligned = |{img_base_q[1:0], flt_base_q[1:0], img_stride_q[1:0], out_x_q[1:0]};

  assign unused_bits = ^{img_addr[1:0], flt_addr[1:0], fx_next[31:16]};

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[i] = (32'(fx_q) + 32'(i)) < 32'(flt_w_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    fx_d      = fx_q;
    fy_d      = fy_q;
    retry_d   = retry_q;
    gap_flt_d = gap_flt_q;
    img_d     = img_q;
    flt_d     = flt_q;
    error_d   = error_q;
    load_cfg  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          load_cfg = 1'b1;
          error_d  = 1'b0;
          retry_d  = '0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (misaligned) begin
          error_d = 1'b1;
          state_d = StDone;
        end else if (flt_w_q == 16'd0 || flt_h_q == 16'd0) begin
          state_d = StDone;
        end else begin
          fx_d    = '0;
          fy_d    = '0;
          state_d = StImgReq;
        end
      end
      StImgReq, StFltReq: begin
        // Error wins over a simultaneous ack.
        if (bus.wb_err) begin
          if (retry_q < RetryMax) begin
            retry_d   = retry_q + 1'b1;
            gap_flt_d = (state_q == StFltReq);
            state_d   = StRetryGap;
          end else begin
            error_d = 1'b1;
            state_d = StDone;
          end
        end else if (bus.wb_ack) begin
          retry_d = '0;
          if (state_q == StImgReq) begin
            img_d   = bus.wb_dat_miso;
            state_d = StFltReq;
          end else begin
            flt_d   = bus.wb_dat_miso;
            state_d = StPresent;
          end
        end
      end
      StRetryGap: state_d = gap_flt_q ? StFltReq : StImgReq;
      StPresent: begin
        if (pair_ready) begin
          if (!last_col) begin
            fx_d = fx_next[15:0];
          end else begin
            fx_d = '0;
            fy_d = fy_q + 16'd1;
          end
          state_d = (last_col && last_row) ? StDone : StImgReq;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fx_q      <= '0;
      fy_q      <= '0;
      retry_q   <= '0;
      gap_flt_q <= 1'b0;
      img_q     <= '0;
      flt_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      fx_q      <= fx_d;
      fy_q      <= fy_d;
      retry_q   <= retry_d;
      gap_flt_q <= gap_flt_d;
      img_q     <= img_d;
      flt_q     <= flt_d;
      error_q   <= error_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img_base_q   <= '0;
      img_stride_q <= '0;
      flt_base_q   <= '0;
      flt_w_q      <= '0;
      flt_h_q      <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else if (load_cfg) begin
      img_base_q   <= cfg_image_base;
      img_stride_q <= cfg_image_stride;
      flt_base_q   <= cfg_filter_base;
      flt_w_q      <= cfg_filter_w;
      flt_h_q      <= cfg_filter_h;
      out_x_q      <= cfg_out_x;
      out_y_q      <= cfg_out_y;
    end
  end

  assign bus.wb_cyc = (state_q == StImgReq) || (state_q == StFltReq);
  assign bus.wb_stb = bus.wb_cyc;
  assign bus.wb_sel = 4'hF;
  assign bus.wb_we  = 1'b0;
  assign bus.wb_adr = (state_q == StImgReq) ? img_addr[31:2] :
                      (state_q == StFltReq) ? flt_addr[31:2] : 30'd0;

  assign pair_valid = (state_q == StPresent);
  assign pair_img   = img_q;
  assign pair_flt   = flt_q;
  assign pair_mask  = pair_valid ? lane_mask : 4'd0;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign error      = error_q;

endmodule

// File: tb/tb_conv_fetch_sequencer.sv
// Self-checking bench: random Wishbone slave with injected errors/stalls, random MAC
// back-pressure, and a loop-based reference model of the filter-window walk.
module tb_conv_fetch_sequencer;
  localparam int MaxRetry = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_image_base = '0;
  logic [15:0] cfg_image_stride = '0;
  logic [31:0] cfg_filter_base = '0;
  logic [15:0] cfg_filter_w = '0;
  logic [15:0] cfg_filter_h = '0;
  logic [15:0] cfg_out_x = '0;
  logic [15:0] cfg_out_y = '0;
  logic        pair_valid, pair_ready;
  logic [31:0] pair_img, pair_flt;
  logic [3:0]  pair_mask;
  logic        busy, done, error;

  conv_fetch_sequencer_if bus ();

  conv_fetch_sequencer #(.MAX_RETRY(MaxRetry)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_image_base   (cfg_image_base),
    .cfg_image_stride (cfg_image_stride),
    .cfg_filter_base  (cfg_filter_base),
    .cfg_filter_w     (cfg_filter_w),
    .cfg_filter_h     (cfg_filter_h),
    .cfg_out_x        (cfg_out_x),
    .cfg_out_y        (cfg_out_y),
    .bus              (bus),
    .pair_valid       (pair_valid),
    .pair_ready       (pair_ready),
    .pair_img         (pair_img),
    .pair_flt         (pair_flt),
    .pair_mask        (pair_mask),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[13:0], 2'b01, a[29:14]} ^ 32'hC3A5_5A3C;
  endfunction

  // Slave / consumer control and observation
  int          plan[256];
  int          read_idx = 0, cur_errs = 0;
  int unsigned stall_pct = 0;
  int          ready_mode = 0;
  int          done_cnt = 0, cyc_cnt = 0, vld_cnt = 0, hold_cnt = 0, max_hold = 0;
  logic        prev_err = 1'b0, prev_pend = 1'b0;
  logic [31:0] prev_img, prev_flt;
  logic [3:0]  prev_mask;
  logic [29:0] att_adr[$];
  logic        att_ok[$];
  logic [31:0] got_img[$], got_flt[$];
  logic [3:0]  got_mask[$];

  // Reference model output
  logic [29:0] exp_adr[$];
  logic        exp_ok[$];
  logic [31:0] exp_img[$], exp_flt[$];
  logic [3:0]  exp_mask[$];
  logic        exp_error;

  initial begin
    bus.wb_ack = 1'b0;
    bus.wb_err = 1'b0;
    bus.wb_dat_miso = '0;
    pair_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.wb_ack = 1'b0;
      bus.wb_err = 1'b0;
      bus.wb_dat_miso = '0;
      if (!reset) begin
        if (prev_err) check_eq("retry_gap_stb", 32'(bus.wb_stb), 0);
        if (bus.wb_cyc) begin
          cyc_cnt++;
          check_eq("wb_sel", 32'(bus.wb_sel), 32'hF);
          check_eq("wb_we", 32'(bus.wb_we), 0);
        end
        if (done) done_cnt++;
        if (pair_valid) vld_cnt++;
      end
      prev_err = 1'b0;
      if (!reset && bus.wb_cyc && bus.wb_stb) begin
        if (cur_errs < ((read_idx < 256) ? plan[read_idx] : 0)) begin
          bus.wb_err = 1'b1;
          bus.wb_ack = ($urandom_range(0, 3) == 0);
          cur_errs++;
          prev_err = 1'b1;
          att_adr.push_back(bus.wb_adr);
          att_ok.push_back(1'b0);
        end else if ($urandom_range(0, 99) >= stall_pct) begin
          bus.wb_ack = 1'b1;
          bus.wb_dat_miso = mem_word(bus.wb_adr);
          read_idx++;
          cur_errs = 0;
          att_adr.push_back(bus.wb_adr);
          att_ok.push_back(1'b1);
        end
      end
      case (ready_mode)
        0:       pair_ready = 1'b1;
        1:       pair_ready = 1'($urandom_range(0, 1));
        default: pair_ready = (hold_cnt >= 5);
      endcase
      if (!reset && pair_valid) begin
        check_eq("valid_no_bus", 32'(bus.wb_cyc), 0);
        if (prev_pend) begin
          check_eq("hold_img", pair_img, prev_img);
          check_eq("hold_flt", pair_flt, prev_flt);
          check_eq("hold_mask", 32'(pair_mask), 32'(prev_mask));
        end
        if (pair_ready) begin
          got_img.push_back(pair_img);
          got_flt.push_back(pair_flt);
          got_mask.push_back(pair_mask);
          prev_pend = 1'b0;
          hold_cnt = 0;
        end else begin
          prev_pend = 1'b1;
          prev_img = pair_img;
          prev_flt = pair_flt;
          prev_mask = pair_mask;
          hold_cnt++;
          if (hold_cnt > max_hold) max_hold = hold_cnt;
        end
      end else begin
        if (!reset && prev_pend) check_eq("valid_dropped", 32'(pair_valid), 1);
        prev_pend = 1'b0;
        hold_cnt = 0;
      end
    end
  end

  task automatic set_cfg(input logic [31:0] ib, input logic [15:0] st, input logic [31:0] fb,
                         input logic [15:0] w, input logic [15:0] h, input logic [15:0] ox,
                         input logic [15:0] oy);
    cfg_image_base = ib;
    cfg_image_stride = st;
    cfg_filter_base = fb;
    cfg_filter_w = w;
    cfg_filter_h = h;
    cfg_out_x = ox;
    cfg_out_y = oy;
  endtask

  task automatic zero_plan();
    for (int k = 0; k < 256; k++) plan[k] = 0;
  endtask

  // Expected read attempts and pairs from the current cfg and error plan.
  task automatic build_model();
    int          k;
    logic        abort;
    logic [31:0] ia, fa, row;
    logic [31:0] a2[2];
    logic [3:0]  m;
    exp_adr.delete(); exp_ok.delete();
    exp_img.delete(); exp_flt.delete(); exp_mask.delete();
    exp_error = 1'b0;
    abort = 1'b0;
    k = 0;
    if (cfg_image_base[1:0] != 0 || cfg_filter_base[1:0] != 0 ||
        cfg_image_stride[1:0] != 0 || cfg_out_x[1:0] != 0) begin
      exp_error = 1'b1;
    end else if (cfg_filter_w != 0 && cfg_filter_h != 0) begin
      row = ((32'(cfg_filter_w) + 32'd3) / 32'd4) * 32'd4;
      for (int fy = 0; fy < int'(cfg_filter_h) && !abort; fy++) begin
        for (int fx = 0; fx < int'(cfg_filter_w) && !abort; fx += 4) begin
          ia = cfg_image_base + (32'(cfg_out_y) + 32'(fy)) * 32'(cfg_image_stride)
             + 32'(cfg_out_x) + 32'(fx);
          fa = cfg_filter_base + 32'(fy) * row + 32'(fx);
          a2[0] = ia;
          a2[1] = fa;
          for (int j = 0; j < 2 && !abort; j++) begin
            for (int e = 0; e < plan[k] && e <= MaxRetry; e++) begin
              exp_adr.push_back(a2[j][31:2]);
              exp_ok.push_back(1'b0);
            end
            if (plan[k] > MaxRetry) begin
              abort = 1'b1;
              exp_error = 1'b1;
            end else begin
              exp_adr.push_back(a2[j][31:2]);
              exp_ok.push_back(1'b1);
            end
            k++;
          end
          if (!abort) begin
            for (int i = 0; i < 4; i++) m[i] = (fx + i < int'(cfg_filter_w));
            exp_img.push_back(mem_word(ia[31:2]));
            exp_flt.push_back(mem_word(fa[31:2]));
            exp_mask.push_back(m);
          end
        end
      end
    end
  endtask

  task automatic do_walk(input string tag);
    bit got;
    build_model();
    att_adr.delete(); att_ok.delete();
    got_img.delete(); got_flt.delete(); got_mask.delete();
    read_idx = 0; cur_errs = 0; done_cnt = 0; cyc_cnt = 0; vld_cnt = 0; max_hold = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Configuration must have been captured at start.
    cfg_image_base = $urandom();
    cfg_filter_base = $urandom();
    cfg_filter_w = 16'($urandom());
    cfg_out_y = 16'($urandom());
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done_cnt > 0) got = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(got), 1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_once"}, 32'(done_cnt), 1);
    check_eq({tag, "_error"}, 32'(error), 32'(exp_error));
    check_eq({tag, "_idle"}, 32'(busy), 0);
    check_eq({tag, "_n_reads"}, 32'(att_adr.size()), 32'(exp_adr.size()));
    for (int i = 0; i < att_adr.size() && i < exp_adr.size(); i++) begin
      check_eq({tag, "_rd_adr"}, 32'(att_adr[i]), 32'(exp_adr[i]));
      check_eq({tag, "_rd_ok"}, 32'(att_ok[i]), 32'(exp_ok[i]));
    end
    check_eq({tag, "_n_pairs"}, 32'(got_img.size()), 32'(exp_img.size()));
    for (int i = 0; i < got_img.size() && i < exp_img.size(); i++) begin
      check_eq({tag, "_img"}, got_img[i], exp_img[i]);
      check_eq({tag, "_flt"}, got_flt[i], exp_flt[i]);
      check_eq({tag, "_mask"}, 32'(got_mask[i]), 32'(exp_mask[i]));
    end
    if (exp_adr.size() == 0) check_eq({tag, "_no_bus"}, 32'(cyc_cnt), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [29:0] e41[4];
    zero_plan();
    #1 reset = 1'b1;
    #2;
    check_eq("rst_cyc", 32'(bus.wb_cyc), 0);
    check_eq("rst_stb", 32'(bus.wb_stb), 0);
    check_eq("rst_adr", 32'(bus.wb_adr), 0);
    check_eq("rst_valid", 32'(pair_valid), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_error", 32'(error), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_img", pair_img, 0);
    check_eq("rst_flt", pair_flt, 0);
    check_eq("rst_mask", 32'(pair_mask), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic 3x2 window, zero-wait slave, always-ready consumer.
    set_cfg(32'h1000, 16, 32'h2000, 3, 2, 4, 1);
    do_walk("basic");
    e41[0] = 30'h405; e41[1] = 30'h800; e41[2] = 30'h409; e41[3] = 30'h801;
    for (int i = 0; i < 4; i++) check_eq("basic_adr_const", 32'(att_adr[i]), 32'(e41[i]));
    check_eq("basic_mask0", 32'(got_mask[0]), 32'h7);
    check_eq("basic_mask1", 32'(got_mask[1]), 32'h7);

    set_cfg(32'h1000, 16, 32'h2000, 6, 1, 4, 1);
    do_walk("wide");
    check_eq("wide_flt_adr0", 32'(att_adr[1]), 32'h800);
    check_eq("wide_flt_adr1", 32'(att_adr[3]), 32'h801);
    check_eq("wide_mask0", 32'(got_mask[0]), 32'hF);
    check_eq("wide_mask1", 32'(got_mask[1]), 32'h3);

    set_cfg(32'h1000, 16, 32'h2000, 3, 2, 4, 1);
    plan[0] = 2;
    do_walk("retry2");
    check_eq("retry2_reissue", 32'(att_adr[2]), 32'h405);
    plan[0] = 4;
    set_cfg(32'h1000, 16, 32'h2000, 3, 2, 4, 1);
    do_walk("abort");
    check_eq("abort_no_valid", 32'(vld_cnt), 0);
    zero_plan();

    ready_mode = 2;
    set_cfg(32'h1000, 16, 32'h2000, 3, 2, 4, 1);
    do_walk("hold");
    check_eq("hold_len", 32'(max_hold), 5);
    ready_mode = 0;

    // Misaligned image base: done exactly two cycles after start, no bus traffic.
    set_cfg(32'h1002, 16, 32'h2000, 3, 2, 4, 1);
    cyc_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("mis_t1_done", 32'(done), 0);
    @(negedge clk);
    check_eq("mis_t2_done", 32'(done), 1);
    check_eq("mis_error", 32'(error), 1);
    @(negedge clk);
    check_eq("mis_t3_done", 32'(done), 0);
    check_eq("mis_sticky", 32'(error), 1);
    check_eq("mis_no_bus", 32'(cyc_cnt), 0);

    set_cfg(32'h1000, 16, 32'h2000, 3, 0, 4, 1);
    do_walk("h0");

    // Asynchronous reset in the middle of a filter read.
    set_cfg(32'h1000, 16, 32'h2000, 3, 2, 4, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.wb_stb && bus.wb_adr == 30'h800) found = 1'b1;
    end
    check_eq("rst_mid_found", 32'(found), 1);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_mid_cyc", 32'(bus.wb_cyc), 0);
    check_eq("rst_mid_stb", 32'(bus.wb_stb), 0);
    check_eq("rst_mid_busy", 32'(busy), 0);
    check_eq("rst_mid_img", pair_img, 0);
    @(negedge clk);
    reset = 1'b0;
    set_cfg(32'h1000, 16, 32'h2000, 3, 2, 4, 1);
    do_walk("after_rst");

    // Randomized walks with stalls, errors and back-pressure.
    stall_pct = 25;
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ib, fb;
      logic [15:0] st, w, h, ox, oy;
      int unsigned r;
      ib = $urandom() & 32'hFFFF_FFFC;
      fb = $urandom() & 32'hFFFF_FFFC;
      st = 16'($urandom_range(0, 63) * 4);
      ox = 16'($urandom_range(0, 31) * 4);
      oy = 16'($urandom_range(0, 20));
      w = 16'($urandom_range(1, 12));
      h = 16'($urandom_range(1, 4));
      r = $urandom_range(0, 19);
      if (r == 0) ib = ib | 32'h1;
      else if (r == 1) st = st | 16'h2;
      else if (r == 2) w = 16'd0;
      else if (r == 3) ox = ox | 16'h1;
      for (int k = 0; k < 256; k++) begin
        r = $urandom_range(0, 39);
        plan[k] = (r < 32) ? 0 : (r < 36) ? 1 : (r < 38) ? 2 : (r < 39) ? 3 : 4;
      end
      set_cfg(ib, st, fb, w, h, ox, oy);
      do_walk("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
